// File: rtl/capture_pll_reconfig_ctrl.sv
// Capture PLL runtime reconfiguration sequencer: programs one C counter through the PLL reconfig IP and waits for stable re-lock.
// Zero-wait, first-poll-done, already-locked latency: done asserts exactly LOCK_STABLE+5 cycles after acceptance.
module capture_pll_reconfig_ctrl #(
    parameter int unsigned NUM_CLOCKS   = 4,
    parameter int unsigned POLL_LIMIT   = 1023,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [4:0]  cfg_counter,
    input  logic [7:0]  cfg_hi,
    input  logic [7:0]  cfg_lo,
    input  logic        cfg_bypass,
    input  logic        cfg_odd,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_MODE, S_WR_C, S_WR_START, S_POLL, S_POLL_GAP, S_LOCK_WAIT, S_FIN, S_FAIL
    } state_t;

    state_t          state, state_nx;
    logic            ready_q;
    logic            lock_m, lock_s;
    logic [4:0]      c_counter;
    logic [7:0]      c_hi, c_lo;
    logic            c_bypass, c_odd;
    logic [PW-1:0]   poll_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [SW-1:0]   stable_cnt;
    logic [1:0]      err_code_q, err_code_nx;
    logic            accept, bad_index, xfer_done;
    logic            unused_readdata;

    assign unused_readdata = ^mgmt_readdata[31:1];

    // ready_q keeps cfg_ready low while reset is asserted even though state is IDLE
    assign cfg_ready = ready_q && (state == S_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign bad_index = ({27'b0, cfg_counter} >= NUM_CLOCKS);
    assign xfer_done = !mgmt_waitrequest;
    assign err_code  = err_code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ready_q    <= 1'b0;
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            err_code_q <= '0;
        end else begin
            state      <= state_nx;
            ready_q    <= 1'b1;
            lock_m     <= pll_locked;
            lock_s     <= lock_m;
            err_code_q <= err_code_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_counter <= '0;
            c_hi      <= '0;
            c_lo      <= '0;
            c_bypass  <= 1'b0;
            c_odd     <= 1'b0;
        end else if (accept) begin
            c_counter <= cfg_counter;
            c_hi      <= cfg_hi;
            c_lo      <= cfg_lo;
            c_bypass  <= cfg_bypass;
            c_odd     <= cfg_odd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt   <= '0;
            tmo_cnt    <= '0;
            stable_cnt <= '0;
        end else begin
            // poll count survives the idle gap between reads, clears everywhere else
            if (state == S_POLL) begin
                if (xfer_done && !mgmt_readdata[0])
                    poll_cnt <= poll_cnt + 1'b1;
            end else if (state != S_POLL_GAP) begin
                poll_cnt <= '0;
            end
            if (state == S_LOCK_WAIT) begin
                tmo_cnt    <= tmo_cnt + 1'b1;
                stable_cnt <= lock_s ? stable_cnt + 1'b1 : '0;
            end else begin
                tmo_cnt    <= '0;
                stable_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        err_code_nx    = err_code_q;
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        mgmt_address   = '0;
        mgmt_read      = 1'b0;
        mgmt_write     = 1'b0;
        mgmt_writedata = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bad_index) begin
                        state_nx    = S_FAIL;
                        err_code_nx = 2'd1;
                    end else begin
                        state_nx = S_WR_MODE;
                    end
                end
            end
            S_WR_MODE: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h00;
                mgmt_writedata = 32'd1;
                if (xfer_done) state_nx = S_WR_C;
            end
            S_WR_C: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h05;
                mgmt_writedata = {9'b0, c_counter, c_odd, c_bypass, c_hi, c_lo};
                if (xfer_done) state_nx = S_WR_START;
            end
            S_WR_START: begin
                busy         = 1'b1;
                mgmt_write   = 1'b1;
                mgmt_address = 6'h02;
                if (xfer_done) state_nx = S_POLL;
            end
            S_POLL: begin
                busy         = 1'b1;
                mgmt_read    = 1'b1;
                mgmt_address = 6'h01;
                if (xfer_done) begin
                    if (mgmt_readdata[0]) begin
                        state_nx = S_LOCK_WAIT;
                    end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                        state_nx    = S_FAIL;
                        err_code_nx = 2'd2;
                    end else begin
                        state_nx = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                busy     = 1'b1;
                state_nx = S_POLL;
            end
            S_LOCK_WAIT: begin
                busy = 1'b1;
                if (lock_s && (stable_cnt == SW'(LOCK_STABLE - 1))) begin
                    state_nx = S_FIN;
                end else if (tmo_cnt == TW'(LOCK_TIMEOUT)) begin
                    state_nx    = S_FAIL;
                    err_code_nx = 2'd3;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_FAIL: begin
                error    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
